// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states and
// the request legality check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StCap,
    StWr,
    StDone
  } lsu_state_e;

  // True when the request must complete immediately with an error.
  function automatic logic lsu_bad(input logic we, input logic [2:0] f3, input logic [1:0] off);
    logic legal;
    logic mis;
    legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
            (!we && ((f3 == F3_BU) || (f3 == F3_HU)));
    if ((f3 == F3_H) || (f3 == F3_HU)) begin
      mis = off[0];
    end else if (f3 == F3_W) begin
      mis = (off != 2'b00);
    end else begin
      mis = 1'b0;
    end
    return !legal || mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic: extracts and extends sub-word loads, merges sub-word stores
// into the previously read memory word. Purely combinational.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [2:0]        funct3,
  input  logic [1:0]        off,
  input  logic [DATA_W-1:0] word,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{off, 3'b000} +: 8];
    half_sel = off[1] ? word[31:16] : word[15:0];

    load_data = word;
    case (funct3)
      F3_B:    load_data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {{(DATA_W-8){1'b0}}, byte_sel};
      F3_H:    load_data = {{(DATA_W-16){half_sel[15]}}, half_sel};
      F3_HU:   load_data = {{(DATA_W-16){1'b0}}, half_sel};
      default: load_data = word;
    endcase

    store_word = word;
    case (funct3)
      F3_B:    store_word[{off, 3'b000} +: 8] = wdata[7:0];
      F3_H:    store_word[{off[1], 4'b0000} +: 16] = wdata[15:0];
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the execute stage and a word-wide data memory without
// byte enables; sub-word stores are performed as read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_e        state_q, state_d;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic              accept;
  logic              req_bad;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] store_word;

  assign accept  = (state_q == StIdle) && req;
  assign req_bad = lsu_bad(we, funct3, addr[1:0]);

  lsu_align #(
    .DATA_W(DATA_W)
  ) u_align (
    .funct3    (funct3_q),
    .off       (addr_q[1:0]),
    .word      (mem_rdata),
    .wdata     (wdata_q),
    .load_data (load_data),
    .store_word(store_word)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (req_bad) begin
            state_d = StDone;
          end else if (we && (funct3 == F3_W)) begin
            state_d = StWr;
          end else begin
            state_d = StRd;
          end
        end
      end
      StRd:    state_d = StCap;
      StCap:   state_d = we_q ? StWr : StDone;
      StWr:    state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      addr_q      <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q     <= we;
        funct3_q <= funct3;
        addr_q   <= addr;
        wdata_q  <= wdata;
        err_q    <= req_bad;
        if (!req_bad && we && (funct3 == F3_W)) begin
          mem_wdata_q <= wdata;
        end
      end
      // Read data is only trusted here; it is high-Z in every other state.
      if (state_q == StCap) begin
        if (we_q) begin
          mem_wdata_q <= store_word;
        end else begin
          rdata_q <= load_data;
        end
      end
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign err       = done && err_q;
  assign rdata     = rdata_q;
  assign mem_addr  = {2'b00, addr_q[DATA_W-1:2]};
  assign mem_wdata = mem_wdata_q;
  // Gated by rst so an access abandoned mid-write never reaches memory.
  assign mem_read  = (state_q == StRd) && !rst;
  assign mem_write = (state_q == StWr) && !rst;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the single-cycle core's execute stage and the word-wide data memory. Translates RISC-V load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses on the memory's MemRead/MemWrite/Address/WriteData/ReadData port. Sub-word loads are extracted and extended; sub-word stores are done as read-modify-write, because memory has no byte enables. Stalls the core with `busy` until completion, flags misaligned/illegal requests.

## Interface
- `DATA_W`, 32: data and byte-address width.
- `clk`  in  1  rising-edge clock, shared with data memory.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  1  start request; sampled only in IDLE.
- `we`  in  1  1 = store, 0 = load.
- `funct3`  in  3  RV32I width/sign code.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data (rs2), low bytes used for SB/SH.
- `busy`  out  1  high whenever state != IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  valid with `done`; misaligned or illegal funct3.
- `rdata`  out  32  load result, held until next successful load.
- `mem_addr`  out  32  word index = latched `addr >> 2`.
- `mem_read`  out  1  drives memory MemRead.
- `mem_write`  out  1  drives memory MemWrite.
- `mem_wdata`  out  32  drives memory WriteData.
- `mem_rdata`  in  32  memory ReadData; registered in memory, high-Z when not reading.

## Operation
- Encodings: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW. Any other code -> illegal.
- Misaligned: halfword with `addr[0]=1`, word with `addr[1:0]!=0`.
- Little-endian: byte k of a word = bits [8k+7:8k], k = `addr[1:0]`; halfword uses `addr[1]`.
- States: IDLE, RD, CAP, WR, DONE.
- IDLE, `req=1`: latch we/funct3/addr/wdata. Illegal or misaligned -> DONE with err=1. SW -> WR with `mem_wdata=wdata`. Otherwise -> RD.
- RD: `mem_read=1`, `mem_write=0`. Next: CAP.
- CAP: `mem_rdata` valid. Load -> extract byte/halfword, sign-extend (LB/LH) or zero-extend (LBU/LHU), register into `rdata`, then DONE. Store -> merge the low byte/halfword of latched wdata into the read word at the selected lane, register the result as `mem_wdata`, then WR.
- WR: `mem_write=1`, `mem_read=0`. Next: DONE.
- DONE: `done=1`. `err` is as latched. Next: IDLE.
- `mem_read` and `mem_write` are never both 1. Both are forced 0 combinationally while `rst=1`.
- `mem_rdata` is sampled only in CAP; Z at any other time is ignored.
- `rdata` is not updated on errored requests or on stores.
- `req` while busy is ignored; it is not queued.

## Timing
- Request accepted at edge E0, where E0 ends the IDLE cycle with `req=1`.
- `done` high in cycle after edge: E1 for error, E2 for SW, E3 for any load, E4 for SB/SH.
- Core must hold nothing after E0, since inputs are latched.
- `rdata` is valid in the same cycle as `done` and is held afterward.
- Back-to-back: the earliest next acceptance is in the IDLE cycle following DONE.
- Reset values: state IDLE; busy, done, err, mem_read, mem_write = 0; rdata, mem_addr, mem_wdata = 0.
- `rst` mid-operation abandons the access. No write reaches memory, including when `rst` is asserted during WR. Next cycle is IDLE.

## Structure
- Package `lsu_pkg`: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the state enum/localparams.
- Sub-module `lsu_align`, purely combinational, holds the lane logic:
  - load extract/extend: funct3, addr[1:0], word -> 32-bit result.
  - store merge: funct3, addr[1:0], old word, wdata -> new word.
- Top holds the FSM and registers.

## Test plan
- LW addr 0x08, memory word 2 = 0x8899AABB -> done after E3, rdata=0x8899AABB, err=0, mem_read high exactly one cycle with mem_addr=2.
- LB addr 0x0B then LBU addr 0x0B on the same word -> rdata=0xFFFFFF88, then 0x00000088.
- SB addr 0x05 wdata 0x123456CD, word 1 = 0x11223344 -> one read, then one write of 0x1122CD44, done after E4.
- SH addr 0x03 -> done after E1, err=1, no mem_read/mem_write pulse, rdata unchanged.
- SW addr 0x0C wdata 0xDEADBEEF -> no read, a single write of 0xDEADBEEF to word 3, done after E2; a `req` asserted while busy is ignored.
- Assert `rst` during WR of an SH -> mem_write=0 in that cycle, memory unchanged, state IDLE, all outputs at reset values.
